// File: rtl/nco_pkg.sv
// Shared constants for the multi-channel quadrature NCO.
// Latency, dither LFSR polynomial/seed and quadrant encoding.
package nco_pkg;

  localparam int LAT = 4;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  // Galois form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0);
  endfunction

endpackage

// File: rtl/nco_qrom.sv
// Quarter-wave sine table, two registered read ports.
// Contents are computed at elaboration from the parameters.
module nco_qrom #(
  parameter int AW  = 10,
  parameter int MPR = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [AW-3:0]     addr_a,
  input  logic [AW-3:0]     addr_b,
  output logic [MPR-2:0]    data_a,
  output logic [MPR-2:0]    data_b
);

  localparam int  IW  = AW - 2;
  localparam int  N   = 1 << IW;
  localparam int  DW  = MPR - 1;
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = (2.0 ** (MPR - 1)) - 1.0;

  logic [DW-1:0] tab [N];

  for (genvar k = 0; k < N; k++) begin : g_tab
    localparam real ANG =
      2.0 * PI * (real'(k) + 0.5) / (2.0 ** AW);
    localparam int VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign tab[k] = DW'(VAL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= tab[addr_a];
      data_b <= tab[addr_b];
    end
  end

endmodule

// File: rtl/nco_mc_quad.sv
// Time-multiplexed multi-channel quadrature NCO, 4-stage pipeline.
// Optional phase dither on the truncation path: define NCO_DITHER_EN.
module nco_mc_quad
  import nco_pkg::*;
#(
  parameter int APR = 32,
  parameter int AW  = 10,
  parameter int MPR = 16,
  parameter int NCH = 4,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  inc_wr,
  input  logic [CW-1:0]         inc_ch,
  input  logic [APR-1:0]        inc_data,
  input  logic                  sync_clr,
  output logic signed [MPR-1:0] sin_o,
  output logic signed [MPR-1:0] cos_o,
  output logic [CW-1:0]         ch_o,
  output logic                  out_valid
);

  localparam int IW = AW - 2;
  localparam int NS = 1 << CW;

  logic [APR-1:0] acc [NS];
  logic [APR-1:0] inc [NS];
  logic [CW-1:0]  cnt;
  logic [APR-1:0] acc_new;
  logic [AW-1:0]  ph_top;
  logic [2:0]     fcnt;

  logic [AW-1:0]  ph1;
  logic [CW-1:0]  ch1, ch2, ch3;
  logic [IW:0]    fs, fc;
  logic [IW-1:0]  addr_s, addr_c;
  logic           neg_s2, neg_c2;
  logic           neg_s3, neg_c3;
  logic [MPR-2:0] mag_s, mag_c;
  logic signed [MPR-1:0] ms, mc;

  assign acc_new = acc[cnt] + inc[cnt];

`ifdef NCO_DITHER_EN
  localparam int DW = (APR - AW < 16) ? APR - AW : 16;
  localparam logic [15:0] DMASK =
    16'((32'd1 << DW) - 32'd1);

  logic [15:0]    lfsr;
  logic [APR-1:0] ph_full;
  logic           unused_low;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (clken) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // dither only reaches the table address, never the accumulator
  assign ph_full    = acc_new + APR'(lfsr & DMASK);
  assign ph_top     = ph_full[APR-1 -: AW];
  assign unused_low = ^ph_full;
`else
  assign ph_top = acc_new[APR-1 -: AW];
`endif

  // stage 1: accumulate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) acc[i] <= '0;
      cnt  <= '0;
      ph1  <= '0;
      ch1  <= '0;
      fcnt <= '0;
    end else if (clken) begin
      if (sync_clr) begin
        for (int i = 0; i < NS; i++) acc[i] <= '0;
        cnt  <= '0;
        ph1  <= '0;
        ch1  <= '0;
        fcnt <= '0;
      end else begin
        acc[cnt] <= acc_new;
        cnt      <= (cnt == CW'(NCH - 1)) ? '0 : cnt + 1'b1;
        ph1      <= ph_top;
        ch1      <= cnt;
        if (fcnt != 3'(LAT)) fcnt <= fcnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) inc[i] <= '0;
    end else if (inc_wr && (32'(inc_ch) < NCH)) begin
      inc[inc_ch] <= inc_data;
    end
  end

  // {negate, table address} for a quadrant/index pair
  function automatic logic [IW:0] fold(
    input quad_e         q,
    input logic [IW-1:0] ix
  );
    logic [IW:0] r;
    r = {1'b0, ix};
    unique case (q)
      Q0: r = {1'b0, ix};
      Q1: r = {1'b0, ~ix};
      Q2: r = {1'b1, ix};
      Q3: r = {1'b1, ~ix};
    endcase
    return r;
  endfunction

  always_comb begin
    fs = fold(quad_e'(ph1[AW-1 -: 2]), ph1[IW-1:0]);
    fc = fold(quad_e'(ph1[AW-1 -: 2] + 2'd1), ph1[IW-1:0]);
  end

  // stage 2: fold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_s <= '0;
      addr_c <= '0;
      neg_s2 <= 1'b0;
      neg_c2 <= 1'b0;
      ch2    <= '0;
    end else if (clken) begin
      addr_s <= fs[IW-1:0];
      addr_c <= fc[IW-1:0];
      neg_s2 <= fs[IW];
      neg_c2 <= fc[IW];
      ch2    <= ch1;
    end
  end

  // stage 3: table read
  nco_qrom #(
    .AW  (AW),
    .MPR (MPR)
  ) u_qrom (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (clken),
    .addr_a  (addr_s),
    .addr_b  (addr_c),
    .data_a  (mag_s),
    .data_b  (mag_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_s3 <= 1'b0;
      neg_c3 <= 1'b0;
      ch3    <= '0;
    end else if (clken) begin
      neg_s3 <= neg_s2;
      neg_c3 <= neg_c2;
      ch3    <= ch2;
    end
  end

  // stage 4: negate and register
  assign ms = $signed({1'b0, mag_s});
  assign mc = $signed({1'b0, mag_c});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sin_o <= '0;
      cos_o <= '0;
      ch_o  <= '0;
    end else if (clken) begin
      sin_o <= neg_s3 ? -ms : ms;
      cos_o <= neg_c3 ? -mc : mc;
      ch_o  <= ch3;
    end
  end

  assign out_valid = clken && (fcnt == 3'(LAT));

endmodule
